salidas_param: RTL and testbench

//  Parametrised successor of the single-port result collector. Walks entry indices 0..num_entries
//  and captures one (found, bounty, nonce) result per entry from the hash core. Emits each result
//  on a valid/ready output port with backpressure, then raises fin.

---
 rtl/salidas_pkg.sv | 15 +
 rtl/salidas_out_reg.sv | 59 +++++
 rtl/salidas_param.sv | 136 +++++++++++++
 tb/tb_salidas_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/salidas_pkg.sv
// Shared definitions for the result collector: FSM state encoding and default widths.
package salidas_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Default geometry
  localparam int DEF_MAX_ENTRIES = 4;
  localparam int DEF_BOUNTY_W    = 24;
  localparam int DEF_NONCE_W     = 32;

endpackage

// File: rtl/salidas_out_reg.sv
// One-entry valid/ready holding register for a captured result.
// Load has priority over the handshake clear; the top only loads while empty.
// Bounty and nonce are zeroed on load when the entry was not found.
module salidas_out_reg
  import salidas_pkg::*;
#(
  parameter int PTR_W    = 2,
  parameter int BOUNTY_W = DEF_BOUNTY_W,
  parameter int NONCE_W  = DEF_NONCE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [PTR_W-1:0]    i_index,
  input  logic                i_found,
  input  logic [BOUNTY_W-1:0] i_bounty,
  input  logic [NONCE_W-1:0]  i_nonce,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [PTR_W-1:0]    o_index,
  output logic                o_found,
  output logic [BOUNTY_W-1:0] o_bounty,
  output logic [NONCE_W-1:0]  o_nonce,
  output logic                o_fire
);

  logic                r_valid;
  logic [PTR_W-1:0]    r_index;
  logic                r_found;
  logic [BOUNTY_W-1:0] r_bounty;
  logic [NONCE_W-1:0]  r_nonce;

  // Valid flag: set on load, dropped on handshake; data holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_index  <= '0;
      r_found  <= 1'b0;
      r_bounty <= '0;
      r_nonce  <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_index  <= i_index;
      r_found  <= i_found;
      r_bounty <= i_found ? i_bounty : '0;
      r_nonce  <= i_found ? i_nonce  : '0;
    end else if (r_valid && i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_index  = r_index;
  assign o_found  = r_found;
  assign o_bounty = r_bounty;
  assign o_nonce  = r_nonce;
  assign o_fire   = r_valid && i_ready;

endmodule

// File: rtl/salidas_param.sv
// Result collector: walks entries 0..num_q, captures one result per entry from
// the search core, emits each on a valid/ready port, then raises fin.
module salidas_param
  import salidas_pkg::*;
#(
  parameter int MAX_ENTRIES = DEF_MAX_ENTRIES,
  parameter int BOUNTY_W    = DEF_BOUNTY_W,
  parameter int NONCE_W     = DEF_NONCE_W,
  localparam int PTR_W      = $clog2(MAX_ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PTR_W-1:0]    num_entries,
  input  logic                in_valid,
  input  logic                in_found,
  input  logic [BOUNTY_W-1:0] in_bounty,
  input  logic [NONCE_W-1:0]  in_nonce,
  output logic [PTR_W-1:0]    rd_ptr,
  output logic                in_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PTR_W-1:0]    out_index,
  output logic                out_found,
  output logic [BOUNTY_W-1:0] out_bounty,
  output logic [NONCE_W-1:0]  out_nonce,
  output logic [PTR_W:0]      found_count,
  output logic                fin
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] MAX_IDX = PTR_W'(MAX_ENTRIES - 1);
  localparam logic [PTR_W:0]   MAX_IDX_W = CNT_W'(MAX_ENTRIES - 1);

  logic [1:0]       r_state, w_next;
  logic [PTR_W-1:0] r_num_q;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_found_cnt;
  logic             r_in_ack;
  logic             r_fin;

  logic [PTR_W-1:0] w_num_clamp;
  logic             w_start_ok;
  logic             w_last;
  logic             w_fire;
  logic             w_load;
  logic             w_advance;
  logic             w_finish;

  // Clamp the requested max index; only matters when MAX_ENTRIES is not a power of two
  assign w_num_clamp = ({1'b0, num_entries} > MAX_IDX_W) ? MAX_IDX : num_entries;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last      = (r_rd_ptr == r_num_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start)    w_next = S_CAPTURE;
      S_CAPTURE: if (in_valid) w_next = S_EMIT;
      S_EMIT:    if (w_fire)   w_next = w_last ? S_DONE : S_CAPTURE;
      S_DONE:    if (start)    w_next = S_CAPTURE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // Per-state strobes driving the datapath
  always_comb begin
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_CAPTURE: w_load = in_valid;
      S_EMIT: begin
        w_advance = w_fire && !w_last;
        w_finish  = w_fire &&  w_last;
      end
      default: ;
    endcase
  end

  // Job bookkeeping: latched size, entry pointer, found counter, ack pulse, fin level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_q     <= '0;
      r_rd_ptr    <= '0;
      r_found_cnt <= '0;
      r_in_ack    <= 1'b0;
      r_fin       <= 1'b0;
    end else begin
      r_in_ack <= w_load;
      if (w_start_ok) begin
        r_num_q     <= w_num_clamp;
        r_rd_ptr    <= '0;
        r_found_cnt <= '0;
        r_fin       <= 1'b0;
      end
      if (w_load)    r_found_cnt <= r_found_cnt + CNT_W'(in_found);
      if (w_advance) r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      if (w_finish)  r_fin       <= 1'b1;
    end
  end

  salidas_out_reg #(
    .PTR_W   (PTR_W),
    .BOUNTY_W(BOUNTY_W),
    .NONCE_W (NONCE_W)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_index (r_rd_ptr),
    .i_found (in_found),
    .i_bounty(in_bounty),
    .i_nonce (in_nonce),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_index (out_index),
    .o_found (out_found),
    .o_bounty(out_bounty),
    .o_nonce (out_nonce),
    .o_fire  (w_fire)
  );

  assign rd_ptr      = r_rd_ptr;
  assign in_ack      = r_in_ack;
  assign found_count = r_found_cnt;
  assign fin         = r_fin;

endmodule

// File: tb/tb_salidas_param.sv
// Directed bench for salidas_param: a table-driven core model feeds results,
// handshakes are recorded and compared against hand-chosen expectations.
module tb_salidas_param;

  localparam int MAXE = 4;
  localparam int PW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] num_entries;
  logic          in_valid;
  logic          in_found;
  logic [23:0]   in_bounty;
  logic [31:0]   in_nonce;
  logic [PW-1:0] rd_ptr;
  logic          in_ack;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_index;
  logic          out_found;
  logic [23:0]   out_bounty;
  logic [31:0]   out_nonce;
  logic [PW:0]   found_count;
  logic          fin;

  salidas_param #(.MAX_ENTRIES(MAXE), .BOUNTY_W(24), .NONCE_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_entries(num_entries),
    .in_valid(in_valid), .in_found(in_found), .in_bounty(in_bounty), .in_nonce(in_nonce),
    .rd_ptr(rd_ptr), .in_ack(in_ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_found(out_found), .out_bounty(out_bounty),
    .out_nonce(out_nonce), .found_count(found_count), .fin(fin)
  );

  always #5 clk = ~clk;

  // Core model: result for the requested entry comes from per-test tables
  logic        fnd_tab[MAXE];
  logic [23:0] bnt_tab[MAXE];
  logic [31:0] non_tab[MAXE];
  assign in_found  = fnd_tab[rd_ptr];
  assign in_bounty = bnt_tab[rd_ptr];
  assign in_nonce  = non_tab[rd_ptr];

  int n_chk = 0;
  int n_err = 0;

  // Recorded handshakes from the last run
  int          n_hs, n_ack, max_ptr, last_hs_cyc, fin_cyc;
  logic [1:0]  rec_idx[16];
  logic        rec_fnd[16];
  logic [23:0] rec_bnt[16];
  logic [31:0] rec_non[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] fpat);
    for (int i = 0; i < MAXE; i++) begin
      fnd_tab[i] = fpat[i];
      bnt_tab[i] = 24'h0A0000 + 24'(i * 'h111);
      non_tab[i] = 32'hC0DE0000 + 32'(i);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the start edge
  task automatic go(input int n);
    @(negedge clk);
    num_entries = n[PW-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe every negedge until fin or budget; a missing fin is a failure
  task automatic run(input int budget);
    n_hs = 0; n_ack = 0; max_ptr = 0; last_hs_cyc = -1; fin_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      if (int'(rd_ptr) > max_ptr) max_ptr = int'(rd_ptr);
      if (in_ack) n_ack++;
      if (fin) begin fin_cyc = c; break; end
      if (out_valid && out_ready && n_hs < 16) begin
        rec_idx[n_hs] = out_index; rec_fnd[n_hs] = out_found;
        rec_bnt[n_hs] = out_bounty; rec_non[n_hs] = out_nonce;
        n_hs++; last_hs_cyc = c;
      end
      @(negedge clk);
    end
    chk("fin_reached", 64'(fin), 64'(1));
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk(tag, 64'(out_valid), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_entries = '0; in_valid = 1'b1; out_ready = 1'b1;
    fill(4'hF);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_fin", 64'(fin), 64'(0));
    chk("rst_rd_ptr", 64'(rd_ptr), 64'(0));
    chk("rst_found_cnt", 64'(found_count), 64'(0));
    chk("rst_in_ack", 64'(in_ack), 64'(0));
    chk("rst_out_data", {out_bounty, out_nonce}, 64'(0));
    reset = 1'b0;

    // 1: four entries back to back, all found
    fill(4'hF);
    go(3); run(40);
    chk("t1_n_hs", 64'(n_hs), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_idx%0d", i), 64'(rec_idx[i]), 64'(i));
      chk($sformatf("t1_bnt%0d", i), 64'(rec_bnt[i]), 64'(24'h0A0000 + 24'(i * 'h111)));
      chk($sformatf("t1_non%0d", i), 64'(rec_non[i]), 64'(32'hC0DE0000 + 32'(i)));
    end
    chk("t1_found_cnt", 64'(found_count), 64'(4));
    chk("t1_acks", 64'(n_ack), 64'(4));
    chk("t1_last_hs_cyc", 64'(last_hs_cyc), 64'(7));
    chk("t1_fin_cyc", 64'(fin_cyc), 64'(8));
    chk("t1_out_valid_done", 64'(out_valid), 64'(0));

    // 2: single entry job
    fill(4'hF);
    bnt_tab[0] = 24'hABCDEF; non_tab[0] = 32'h12345678;
    go(0); run(20);
    chk("t2_n_hs", 64'(n_hs), 64'(1));
    chk("t2_found", 64'(rec_fnd[0]), 64'(1));
    chk("t2_bnt", 64'(rec_bnt[0]), 64'(24'hABCDEF));
    chk("t2_non", 64'(rec_non[0]), 64'(32'h12345678));
    chk("t2_max_ptr", 64'(max_ptr), 64'(0));
    chk("t2_rd_ptr", 64'(rd_ptr), 64'(0));

    // 3: backpressure holds the output and freezes the walk
    fill(4'hF);
    out_ready = 1'b0;
    go(1);
    wait_valid("t3_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(out_valid), 64'(1));
      chk("t3_hold_data", {6'(out_index), out_bounty, out_nonce}, {6'(0), 24'h0A0000, 32'hC0DE0000});
      chk("t3_no_ack", 64'(in_ack), 64'(0));
      chk("t3_ptr_frozen", 64'(rd_ptr), 64'(0));
    end
    out_ready = 1'b1;
    run(20);
    chk("t3_n_hs", 64'(n_hs), 64'(2));
    chk("t3_idx0", 64'(rec_idx[0]), 64'(0));
    chk("t3_idx1", 64'(rec_idx[1]), 64'(1));

    // 4: entry 1 not found -> payload zeroed, not counted
    fill(4'b0101);
    non_tab[1] = 32'hFFFFFFFF; bnt_tab[1] = 24'h777777;
    go(2); run(30);
    chk("t4_n_hs", 64'(n_hs), 64'(3));
    chk("t4_found1", 64'(rec_fnd[1]), 64'(0));
    chk("t4_non1", 64'(rec_non[1]), 64'(0));
    chk("t4_bnt1", 64'(rec_bnt[1]), 64'(0));
    chk("t4_non2", 64'(rec_non[2]), 64'(32'hC0DE0002));
    chk("t4_found_cnt", 64'(found_count), 64'(2));

    // 5: mid-job start and size change ignored; start in DONE begins a new job
    fill(4'hF);
    out_ready = 1'b0;
    go(1);
    @(negedge clk); num_entries = 2'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    out_ready = 1'b1;
    run(30);
    chk("t5_n_hs", 64'(n_hs), 64'(2));
    chk("t5_max_ptr", 64'(max_ptr), 64'(1));
    chk("t5_found_cnt", 64'(found_count), 64'(2));
    go(0);
    chk("t5_fin_cleared", 64'(fin), 64'(0));
    chk("t5_cnt_cleared", 64'(found_count), 64'(0));
    run(20);
    chk("t5b_n_hs", 64'(n_hs), 64'(1));
    chk("t5b_found_cnt", 64'(found_count), 64'(1));

    // 6: async reset during EMIT, then oversized request
    fill(4'hF);
    out_ready = 1'b0;
    go(2);
    wait_valid("t6_valid");
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'(0));
    chk("t6_async_data", {out_bounty, out_nonce}, 64'(0));
    chk("t6_async_cnt", 64'(found_count), 64'(0));
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    go(7); run(40);
    chk("t6_n_hs", 64'(n_hs), 64'(4));
    chk("t6_max_ptr", 64'(max_ptr), 64'(3));
    chk("t6_idx3", 64'(rec_idx[3]), 64'(3));
    chk("t6_found_cnt", 64'(found_count), 64'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
